pipelined_barrel_shifter: RTL and testbench

//  N-bit barrel shifter with a pipeline and valid/ready flow control.

---
 rtl/pipelined_barrel_shifter_if.sv | 31 +++
 rtl/pipelined_barrel_shifter.sv | 150 +++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operand and result bundle for the pipelined barrel shifter.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned N = 32
);
    localparam int unsigned B = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [B-1:0] in_shamt;
    logic [2:0]   in_op;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_carry;
    logic         out_zero;
    logic         out_err;

    // Producer of operations and consumer of results.
    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );

    // The shifter itself.
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log-stage barrel shifter (LSL/LSR/ASR/ROL/ROR) with carry/zero/error flags.
// PIPE=1 registers every log stage (latency B); PIPE=0 keeps one output register.
module pipelined_barrel_shifter #(
    parameter int unsigned N    = 32,
    parameter bit          PIPE = 1'b1
) (
    input logic                       clk,
    input logic                       rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int unsigned B  = $clog2(N);
    localparam int unsigned NS = PIPE ? B : 1;

    localparam logic [2:0] OpLsl = 3'd0;
    localparam logic [2:0] OpLsr = 3'd1;
    localparam logic [2:0] OpAsr = 3'd2;
    localparam logic [2:0] OpRol = 3'd3;
    localparam logic [2:0] OpRor = 3'd4;

    typedef struct packed {
        logic [N-1:0] data;
        logic [2:0]   op;
        logic [B-1:0] shamt;
        logic         carry;
    } stage_t;

    // One log stage: shift by 2**k if shamt bit k is set. The carry kept is the
    // last bit pushed out so far; the highest set stage therefore leaves the
    // overall last bit out, which also equals the wrapped bit for rotates.
    function automatic stage_t shift_stage(input stage_t s, input int unsigned k);
        stage_t       r;
        int unsigned  m;
        logic [B-1:0] sh;
        logic [N-1:0] lo_out;
        logic [N-1:0] hi_out;
        r      = s;
        m      = 1 << k;
        sh     = s.shamt >> k;
        lo_out = s.data >> (m - 1);  // bit m-1 lands at position 0
        hi_out = s.data << (m - 1);  // bit N-m lands at position N-1
        if (sh[0]) begin
            unique case (s.op)
                OpLsl: begin
                    r.data  = s.data << m;
                    r.carry = hi_out[N-1];
                end
                OpLsr: begin
                    r.data  = s.data >> m;
                    r.carry = lo_out[0];
                end
                OpAsr: begin
                    r.data  = $signed(s.data) >>> m;
                    r.carry = lo_out[0];
                end
                OpRol: begin
                    r.data  = (s.data << m) | (s.data >> (N - m));
                    r.carry = hi_out[N-1];
                end
                OpRor: begin
                    r.data  = (s.data >> m) | (s.data << (N - m));
                    r.carry = lo_out[0];
                end
                default: r = s;  // illegal op passes through untouched
            endcase
        end
        return r;
    endfunction

    stage_t        st_q [NS];
    stage_t        st_d [NS];
    logic [NS-1:0] v_q;
    logic [NS-1:0] v_d;
    logic [NS-1:0] adv;
    logic [NS-1:0] ld;
    logic [NS-1:0] en;
    logic          zero_q;
    logic          zero_d;
    logic          err_q;
    logic          err_d;

    // Backpressure chain: a stage loads when empty or when it advances this cycle.
    always_comb begin
        logic down_ready;
        adv        = '0;
        ld         = '0;
        down_ready = bus.out_ready;
        for (int j = int'(NS) - 1; j >= 0; j--) begin
            adv[j]     = v_q[j] & down_ready;
            ld[j]      = ~v_q[j] | adv[j];
            down_ready = ld[j];
        end
    end

    // Forward datapath: each register applies its log stage(s) to its upstream.
    always_comb begin
        stage_t up;
        stage_t nxt;
        logic   up_v;
        up   = '{data: bus.in_data, op: bus.in_op, shamt: bus.in_shamt, carry: 1'b0};
        up_v = bus.in_valid;
        nxt  = up;
        en   = '0;
        v_d  = v_q;
        for (int j = 0; j < int'(NS); j++) begin
            nxt = up;
            for (int k = 0; k < int'(B); k++) begin
                if (!PIPE || k == j) begin
                    nxt = shift_stage(nxt, k);
                end
            end
            st_d[j] = nxt;
            en[j]   = ld[j] & up_v;
            v_d[j]  = ld[j] ? up_v : v_q[j];
            up      = st_q[j];
            up_v    = v_q[j];
        end
        zero_d = (st_d[NS-1].data == '0);
        err_d  = (st_d[NS-1].op > OpRor);
    end

    // Stage registers; flags are captured alongside the final stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(NS); j++) begin
                st_q[j] <= '0;
            end
            v_q    <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int j = 0; j < int'(NS); j++) begin
                if (en[j]) begin
                    st_q[j] <= st_d[j];
                end
            end
            v_q <= v_d;
            if (en[NS-1]) begin
                zero_q <= zero_d;
                err_q  <= err_d;
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v_q[NS-1];
    assign bus.out_data  = st_q[NS-1].data;
    assign bus.out_carry = st_q[NS-1].carry;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for the pipelined barrel shifter at N=8, PIPE=1.
module tb_pipelined_barrel_shifter;
    localparam int unsigned N = 8;
    localparam int unsigned B = 3;

    typedef struct packed {
        logic [N-1:0] d;
        logic         c;
        logic         z;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.N(N)) bus ();
    pipelined_barrel_shifter #(.N(N), .PIPE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    bit   rand_ready  = 1'b0;
    logic rnd_ready   = 1'b0;
    logic fixed_ready = 1'b0;
    assign bus.out_ready = rand_ready ? rnd_ready : fixed_ready;

    // Reference model written directly from the operation definitions.
    function automatic exp_t model(input logic [N-1:0] d, input logic [2:0] s,
                                   input logic [2:0] op);
        exp_t         r;
        logic [N-1:0] t;
        int unsigned  sh;
        sh  = s;
        r.d = d;
        r.c = 1'b0;
        r.e = 1'b0;
        case (op)
            3'd0: begin
                r.d = d << sh;
                t   = d >> (N - sh);
                if (sh != 0) r.c = t[0];
            end
            3'd1: begin
                r.d = d >> sh;
                t   = d >> (sh - 1);
                if (sh != 0) r.c = t[0];
            end
            3'd2: begin
                r.d = $signed(d) >>> sh;
                t   = d >> (sh - 1);
                if (sh != 0) r.c = t[0];
            end
            3'd3: begin
                r.d = (d << sh) | (d >> (N - sh));
                if (sh != 0) r.c = r.d[0];
            end
            3'd4: begin
                r.d = (d >> sh) | (d << (N - sh));
                if (sh != 0) r.c = r.d[N-1];
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.d == '0);
        return r;
    endfunction

    // Random consumer readiness, changed well clear of the sampling edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: pops expectations on each output transfer, checks stall hold.
    initial begin
        exp_t cur;
        exp_t held;
        exp_t e;
        bit   stall_prev;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                cur = {bus.out_data, bus.out_carry, bus.out_zero, bus.out_err};
                if (stall_prev) begin
                    checks++;
                    if (bus.out_valid !== 1'b1 || cur !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b out=%h, required valid=1 out=%h",
                                 bus.out_valid, cur, held);
                    end
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got %h, required no output", cur);
                    end else begin
                        e = sb.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL result: got {d,c,z,e}=%h, required %h", cur, e);
                        end
                    end
                end
                stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
                held       = cur;
            end
        end
    end

    // Offer one op (called at posedge+1); returns at posedge+1 after its handshake.
    task automatic send(input logic [N-1:0] d, input logic [2:0] s, input logic [2:0] op,
                        input exp_t e);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_shamt = '0;
        bus.in_op    = '0;
        fixed_ready  = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", bus.out_valid);
        end
        checks++;
        if ({bus.out_data, bus.out_carry, bus.out_zero, bus.out_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b, required 0", bus.out_data,
                     bus.out_carry, bus.out_zero, bus.out_err);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b, required 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        int cnt;
        fixed_ready = 1'b1;
        send(8'h81, 3'd1, 3'd0, '{d: 8'h02, c: 1'b1, z: 1'b0, e: 1'b0});
        bus.in_valid = 1'b0;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (cnt != int'(B) || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got %0d cycles (valid=%b), required %0d", cnt,
                     bus.out_valid, B);
        end
        checks++;
        if (bus.out_data !== 8'h02 || bus.out_carry !== 1'b1 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL lsl_first: got %h c=%b z=%b, required 02 c=1 z=0", bus.out_data,
                     bus.out_carry, bus.out_zero);
        end
        @(posedge clk);
        #1;
        send(8'h81, 3'd7, 3'd1, '{d: 8'h01, c: 1'b0, z: 1'b0, e: 1'b0});
        send(8'h90, 3'd3, 3'd2, '{d: 8'hF2, c: 1'b0, z: 1'b0, e: 1'b0});
        send(8'h01, 3'd1, 3'd4, '{d: 8'h80, c: 1'b1, z: 1'b0, e: 1'b0});
        send(8'h80, 3'd1, 3'd3, '{d: 8'h01, c: 1'b1, z: 1'b0, e: 1'b0});
        send(8'h01, 3'd0, 3'd0, '{d: 8'h01, c: 1'b0, z: 1'b0, e: 1'b0});
        send(8'h0F, 3'd4, 3'd1, '{d: 8'h00, c: 1'b1, z: 1'b1, e: 1'b0});
        send(8'h0F, 3'd2, 3'd7, '{d: 8'h0F, c: 1'b0, z: 1'b0, e: 1'b1});
        bus.in_valid = 1'b0;
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL directed_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_stream();
        logic [N-1:0] d;
        logic [2:0]   s;
        logic [2:0]   op;
        rand_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d  = N'($urandom);
            s  = 3'($urandom_range(0, 7));
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                              : 3'($urandom_range(0, 4));
            send(d, s, op, model(d, s, op));
        end
        bus.in_valid = 1'b0;
        rand_ready   = 1'b0;
        fixed_ready  = 1'b1;
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_lost: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_fill_drain();
        int acc;
        int cnt;
        logic [N-1:0] d;
        fixed_ready  = 1'b0;
        acc          = 0;
        bus.in_valid = 1'b1;
        bus.in_shamt = 3'd2;
        bus.in_op    = 3'd3;
        for (int i = 0; i < 10; i++) begin
            d           = N'(8'h11 * (i + 1));
            bus.in_data = d;
            @(negedge clk);
            if (bus.in_ready !== 1'b1) break;
            sb.push_back(model(d, 3'd2, 3'd3));
            acc++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (acc != int'(B)) begin
            errors++;
            $display("FAIL fill_accepts: got %0d, required %0d", acc, B);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_stalled: got in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        fixed_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_passthrough: got in_ready=%b, required 1", bus.in_ready);
        end
        cnt = 0;
        for (int i = 0; i < int'(B) + 3; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1) break;
            cnt++;
        end
        checks++;
        if (cnt != int'(B)) begin
            errors++;
            $display("FAIL drain_rate: got %0d consecutive results, required %0d", cnt, B);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        fixed_ready = 1'b1;
        send(8'hA5, 3'd1, 3'd0, model(8'hA5, 3'd1, 3'd0));
        send(8'h3C, 3'd2, 3'd4, model(8'h3C, 3'd2, 3'd4));
        send(8'hF0, 3'd3, 3'd2, model(8'hF0, 3'd3, 3'd2));
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h, required 0/00", bus.out_valid,
                     bus.out_data);
        end
        sb.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01, 3'd1, 3'd4, '{d: 8'h80, c: 1'b1, z: 1'b0, e: 1'b0});
        bus.in_valid = 1'b0;
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_op: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_fill_drain();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "watchdog");
    end
endmodule
